// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response channel between the fetch stage and imem.
interface fetch_unit_if;
  localparam int unsigned XLEN = 32;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [XLEN-1:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: drives the PC register input, talks to a variable-latency
// imem, fills IF/ID with a one-entry hold buffer and drains fetches killed by redirects.
module fetch_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       pc,
  output logic [31:0]       pc_next,
  fetch_unit_if.master      mem,
  input  logic              id_stall,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_target,
  output logic              if_id_valid,
  output logic [31:0]       if_id_instr,
  output logic [31:0]       if_id_pc,
  output logic [31:0]       if_id_pc_plus4,
  output logic              fetch_timeout
);
  localparam int unsigned XLEN  = 32;
  localparam int unsigned TMO_W = 16;

  localparam logic [1:0] ST_ISSUE = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
  } ifid_t;

  logic [1:0]       state, state_d;
  logic [XLEN-1:0]  req_addr;
  logic [XLEN-1:0]  fetch_pc;
  logic             fetch_ack;
  logic             can_load;
  ifid_t            fetch_word;
  ifid_t            hold;
  ifid_t            ifid;
  logic [TMO_W-1:0] tmo_cnt, tmo_cnt_d;
  logic             tmo_hit;

  assign can_load   = !if_id_valid || !id_stall;
  assign fetch_pc   = (state == ST_WAIT) ? req_addr : pc;
  assign fetch_word = {mem.imem_rdata, fetch_pc, fetch_pc + XLEN'(4)};

  assign if_id_instr    = ifid.instr;
  assign if_id_pc       = ifid.pc;
  assign if_id_pc_plus4 = ifid.pc_plus4;

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= ST_ISSUE;
    else       state <= state_d;
  end

  // Next state, memory request and PC steering
  always_comb begin
    state_d       = state;
    pc_next       = pc;
    mem.imem_req  = 1'b0;
    mem.imem_addr = pc;
    fetch_ack     = 1'b0;
    case (state)
      ST_ISSUE, ST_WAIT: begin
        mem.imem_req  = 1'b1;
        mem.imem_addr = fetch_pc;
        if (mem.imem_ack) begin
          fetch_ack = 1'b1;
          pc_next   = pc + XLEN'(4);
          state_d   = can_load ? ST_ISSUE : ST_FULL;
        end else begin
          state_d   = ST_WAIT;
        end
      end
      ST_FULL:  if (!id_stall)     state_d = ST_ISSUE;
      ST_DRAIN: if (mem.imem_ack)  state_d = ST_ISSUE;
    endcase
    // A taken branch kills whatever this cycle would have delivered
    if (redirect_valid) begin
      pc_next   = redirect_target & 32'hFFFF_FFFC;
      fetch_ack = 1'b0;
      case (state)
        ST_FULL: state_d = ST_ISSUE;
        default: state_d = mem.imem_ack ? ST_ISSUE : ST_DRAIN;
      endcase
    end
    if (reset) begin
      mem.imem_req = 1'b0;
      pc_next      = pc;
    end
  end

  // Timeout counter: counts unanswered WAIT/DRAIN cycles, saturating
  always_comb begin
    tmo_cnt_d = tmo_cnt;
    if (mem.imem_ack || state_d == ST_ISSUE)
      tmo_cnt_d = '0;
    else if ((state == ST_WAIT || state == ST_DRAIN) && tmo_cnt != '1)
      tmo_cnt_d = tmo_cnt + TMO_W'(1);
  end
  assign tmo_hit = (TIMEOUT_CYCLES != 0) && (tmo_cnt_d == TMO_W'(TIMEOUT_CYCLES));

  // IF/ID register, hold buffer and timeout flag
  always_ff @(posedge clock) begin
    if (reset) begin
      req_addr      <= '0;
      hold          <= '0;
      ifid          <= '0;
      if_id_valid   <= 1'b0;
      tmo_cnt       <= '0;
      fetch_timeout <= 1'b0;
    end else begin
      if (state == ST_ISSUE) req_addr <= pc;

      if (redirect_valid) begin
        if_id_valid <= 1'b0;
      end else if (fetch_ack && can_load) begin
        ifid        <= fetch_word;
        if_id_valid <= 1'b1;
      end else if (state == ST_FULL && !id_stall) begin
        ifid        <= hold;
        if_id_valid <= 1'b1;
      end else if (!id_stall) begin
        if_id_valid <= 1'b0;
      end

      if (redirect_valid)             hold <= '0;
      else if (fetch_ack && !can_load) hold <= fetch_word;

      tmo_cnt <= tmo_cnt_d;
      if (tmo_hit) fetch_timeout <= 1'b1;
    end
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage that sits directly downstream of the 32-bit PC register. It consumes the PC register output and drives the PC register input, so it decides every cycle whether the PC advances, holds, or is redirected. It issues requests to a variable-latency instruction memory and fills the IF/ID pipeline register, with a one-entry hold buffer for decode back-pressure. It also drains fetches that are in flight when a branch or jump redirect arrives.

Parameters:
TIMEOUT_CYCLES, 255, number of cycles without imem_ack in WAIT/DRAIN before fetch_timeout sets; 0 disables; max 65535 (16-bit counter)

Ports:
clock  input  1  single system clock; all state updates on posedge
reset  input  1  synchronous, active-high reset
pc  input  32  current PC from the PC register output
pc_next  output  32  next PC, wired to the PC register input; combinational
imem_req  output  1  instruction memory request
imem_addr  output  32  word address of the request
imem_ack  input  1  one-cycle pulse; imem_rdata valid in the same cycle
imem_rdata  input  32  instruction word
id_stall  input  1  decode cannot consume IF/ID this cycle
redirect_valid  input  1  branch or jump taken this cycle
redirect_target  input  32  redirect destination
if_id_valid  output  1  IF/ID register holds a valid instruction
if_id_instr  output  32  fetched instruction
if_id_pc  output  32  PC of the fetched instruction
if_id_pc_plus4  output  32  if_id_pc + 4
fetch_timeout  output  1  sticky memory-timeout flag

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset effects: state goes to ISSUE. if_id_valid, if_id_instr, if_id_pc, if_id_pc_plus4, the hold buffer, the timeout counter and fetch_timeout all go to 0.
- During reset: imem_req=0 and pc_next=pc. The instruction memory shares the same reset, so no ack from before reset is honoured.
- States:
  - ISSUE: start a fetch of pc.
  - WAIT: fetch outstanding.
  - FULL: instruction parked in the hold buffer.
  - DRAIN: discarding an ack for a killed fetch.
- can_load = !if_id_valid || !id_stall.
- IF/ID consumption: when if_id_valid && !id_stall && nothing loads this cycle, if_id_valid goes 0 at the edge.
- ISSUE: imem_req=1, imem_addr=pc.
  - ack && can_load: load IF/ID with {imem_rdata, pc, pc+4}, pc_next=pc+4, stay in ISSUE. Throughput is 1 instr/cycle with zero-wait memory.
  - ack && !can_load: capture into hold buffer, pc_next=pc+4, go to FULL.
  - no ack: latch req_addr=pc, pc_next=pc, go to WAIT.
- WAIT: imem_req=1, imem_addr=req_addr (stable until ack), pc_next=pc.
  - On ack: same load/hold split as ISSUE; pc_next=pc+4; next state ISSUE or FULL.
- FULL: imem_req=0, pc_next=pc.
  - When !id_stall: move the hold buffer into IF/ID, go to ISSUE.
- DRAIN: imem_req=0, pc_next=pc.
  - On ack: discard data, go to ISSUE.
- Request acceptance: a request is accepted by memory the first cycle imem_req=1. Memory must eventually ack every accepted request exactly once.
- Redirect has highest priority, in any state, and overrides id_stall:
  - pc_next={redirect_target[31:2],2'b00}.
  - At the edge: if_id_valid<=0 and the hold buffer is invalidated.
  - Next state:
    - ISSUE or WAIT without ack that cycle: go to DRAIN.
    - ISSUE or WAIT with ack that cycle: data dropped, go to ISSUE.
    - FULL: go to ISSUE.
    - DRAIN: stay in DRAIN unless ack, then go to ISSUE.
- Arithmetic: pc+4 wraps modulo 2^32 (32'hFFFFFFFC -> 32'h00000000). if_id_pc_plus4 is computed with the same wrap.
- Timeout counter:
  - Increments each cycle in WAIT or DRAIN without ack; clears on ack or on entering ISSUE.
  - When it reaches TIMEOUT_CYCLES (nonzero), fetch_timeout<=1 and stays set until reset.
  - The FSM keeps waiting; the counter saturates.
- Reset mid-operation (any state, including WAIT/DRAIN/FULL): the next cycle is ISSUE with all outputs at reset values.

Test Plan:
- Reset, then zero-wait memory acking every cycle with rdata=addr^32'hA5A5A5A5 -> PCs 0,4,8,12 appear on if_id_pc on consecutive cycles. if_id_instr matches each PC and if_id_valid is 1 continuously.
- Memory with 3-cycle latency fetching pc=0x40 -> imem_req held 3 cycles with imem_addr=0x40, pc_next=0x40 throughout. On ack, if_id_pc=0x40 and pc advances to 0x44.
- id_stall=1 for 4 cycles while a zero-wait fetch of 0x10 acks with IF/ID already full -> state FULL, imem_req=0, pc holds 0x14. After the stall drops, if_id_pc=0x10 with no instruction lost or duplicated.
- redirect_valid with target 0x203 while a fetch of 0x80 is in WAIT -> pc_next=0x200, if_id_valid=0 next cycle, state DRAIN. The 0x80 ack is discarded, then the 0x200 fetch is issued.
- pc=0xFFFFFFFC acked -> if_id_pc_plus4=0 and pc_next=0.
- TIMEOUT_CYCLES=8 with a memory that never acks -> fetch_timeout rises after 8 waiting cycles and stays 1. A synchronous reset clears it and the state returns to ISSUE.
